feature_vote: RTL and testbench

Parametrised successor to the per-feature thresholding stage. It captures N_CH feature outputs and their baselines on a window strobe and evaluates them serially through one shared scale multiplier. Each channel is gated by a persistence counter, and the resulting per-channel binaries are combined into a k-of-N alarm. It sits between the feature extractors (line length, nonlinear energy, band powers) and the detection/report logic. Scale factors are runtime-writable registers, not elaboration constants.

---
 rtl/feature_vote_pkg.sv | 33 +++
 rtl/feature_persist.sv | 40 ++++
 rtl/feature_vote.sv | 126 ++++++++++++
 tb/tb_feature_vote.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/feature_vote_pkg.sv
// Shared types and helpers for the k-of-N feature voting stage.
// Holds the FSM encoding, default widths, the compare-width rule and the popcount.
package feature_vote_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    VOTE = 2'd2
  } state_e;

  localparam int N_CH_DEF       = 6;
  localparam int OUT_W_DEF      = 72;
  localparam int BASE_W_DEF     = 50;
  localparam int SCALE_W_DEF    = 8;
  localparam int SCALE_INIT_DEF = 1;
  localparam int CNT_W_DEF      = 4;
  localparam int POP_W          = 32;

  // Wide enough to hold both the feature and the full base*scale product.
  function automatic int cmp_width(input int out_w, input int base_w, input int scale_w);
    int prod_w;
    prod_w = base_w + scale_w + 1;
    return (out_w > prod_w) ? out_w : prod_w;
  endfunction

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_W; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/feature_persist.sv
// Per-channel persistence gate: saturating hit counter plus registered decision.
// Only acts in the cycle its channel is being evaluated.
module feature_persist #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             hit_i,
  input  logic [CNT_W-1:0] k_i,
  output logic             binary_o
);

  logic [CNT_W-1:0] k_eff;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             binary_q;

  assign k_eff = (k_i == '0) ? CNT_W'(1) : k_i;
  // Saturating at k also pulls an over-limit count back down after k is lowered.
  assign cnt_d = (cnt_q >= k_eff) ? k_eff : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      binary_q <= 1'b0;
    end else if (en_i) begin
      if (hit_i) begin
        cnt_q    <= cnt_d;
        binary_q <= (cnt_d >= k_eff);
      end else begin
        cnt_q    <= '0;
        binary_q <= 1'b0;
      end
    end
  end

  assign binary_o = binary_q;

endmodule

// File: rtl/feature_vote.sv
// Captures N_CH feature/baseline pairs per window, thresholds them serially through
// one shared scale multiplier, gates each by persistence and forms a k-of-N alarm.
module feature_vote
  import feature_vote_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int BASE_W     = BASE_W_DEF,
  parameter int SCALE_W    = SCALE_W_DEF,
  parameter int SCALE_INIT = SCALE_INIT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      win_stb,
  input  logic [N_CH*OUT_W-1:0]     feat_out,
  input  logic [N_CH*BASE_W-1:0]    feat_base,
  input  logic [N_CH-1:0]           feat_valid,
  input  logic                      scale_wr,
  input  logic [$clog2(N_CH)-1:0]   scale_idx,
  input  logic [SCALE_W-1:0]        scale_data,
  input  logic [CNT_W-1:0]          persist_k,
  input  logic [$clog2(N_CH+1)-1:0] vote_min,
  output logic [N_CH-1:0]           binary,
  output logic                      alarm,
  output logic                      alarm_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int CH_W   = $clog2(N_CH);
  localparam int PROD_W = BASE_W + SCALE_W + 1;
  localparam int CMP_W  = cmp_width(OUT_W, BASE_W, SCALE_W);

  state_e                   state_q;
  logic [CH_W-1:0]          ch_q;
  logic                     alarm_q;
  logic                     alarm_valid_q;
  logic                     overrun_q;
  logic signed [OUT_W-1:0]  out_q   [N_CH];
  logic signed [BASE_W-1:0] base_q  [N_CH];
  logic [SCALE_W-1:0]       scale_q [N_CH];
  logic [N_CH-1:0]          valid_q;
  logic [N_CH-1:0]          eval_sel;
  logic                     capture;
  logic signed [PROD_W-1:0] prod;
  logic signed [CMP_W-1:0]  lhs;
  logic signed [CMP_W-1:0]  rhs;
  logic                     hit;

  assign capture = (state_q == IDLE) && win_stb;

  // Scale is zero-extended so a top-bit scale never flips the product's sign.
  assign prod = PROD_W'(base_q[ch_q]) * PROD_W'($signed({1'b0, scale_q[ch_q]}));
  assign lhs  = CMP_W'(out_q[ch_q]);
  assign rhs  = CMP_W'(prod);
  assign hit  = valid_q[ch_q] && (lhs >= rhs);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q[gi]   <= '0;
        base_q[gi]  <= '0;
        valid_q[gi] <= 1'b0;
        scale_q[gi] <= SCALE_W'(SCALE_INIT);
      end else begin
        if (capture) begin
          out_q[gi]   <= feat_out[gi*OUT_W +: OUT_W];
          base_q[gi]  <= feat_base[gi*BASE_W +: BASE_W];
          valid_q[gi] <= feat_valid[gi];
        end
        if (scale_wr && (scale_idx == CH_W'(gi))) scale_q[gi] <= scale_data;
      end
    end

    assign eval_sel[gi] = (state_q == EVAL) && (ch_q == CH_W'(gi));

    feature_persist #(.CNT_W(CNT_W)) u_persist (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (eval_sel[gi]),
      .hit_i    (hit),
      .k_i      (persist_k),
      .binary_o (binary[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      alarm_q       <= 1'b0;
      alarm_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      alarm_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (win_stb) begin
            state_q <= EVAL;
            ch_q    <= '0;
          end
        end
        EVAL: begin
          overrun_q <= win_stb;
          if (ch_q == CH_W'(N_CH - 1)) state_q <= VOTE;
          else ch_q <= ch_q + 1'b1;
        end
        VOTE: begin
          overrun_q     <= win_stb;
          alarm_q       <= popcount({{(POP_W - N_CH){1'b0}}, binary}) >= 32'(vote_min);
          alarm_valid_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alarm       = alarm_q;
  assign alarm_valid = alarm_valid_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_feature_vote.sv
// Directed bench for feature_vote: thresholds, signed extremes, persistence, voting,
// overrun, scale-write timing and mid-window reset.
module tb_feature_vote;

  localparam int N_CH = 6;
  localparam int OUT_W = 72;
  localparam int BASE_W = 50;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      win_stb = 1'b0;
  logic [N_CH*OUT_W-1:0]     feat_out = '0;
  logic [N_CH*BASE_W-1:0]    feat_base = '0;
  logic [N_CH-1:0]           feat_valid = '0;
  logic                      scale_wr = 1'b0;
  logic [2:0]                scale_idx = '0;
  logic [7:0]                scale_data = '0;
  logic [3:0]                persist_k = 4'd1;
  logic [2:0]                vote_min = 3'd3;
  logic [N_CH-1:0]           binary;
  logic                      alarm;
  logic                      alarm_valid;
  logic                      busy;
  logic                      overrun;

  int checks = 0;
  int errors = 0;

  feature_vote dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .win_stb     (win_stb),
    .feat_out    (feat_out),
    .feat_base   (feat_base),
    .feat_valid  (feat_valid),
    .scale_wr    (scale_wr),
    .scale_idx   (scale_idx),
    .scale_data  (scale_data),
    .persist_k   (persist_k),
    .vote_min    (vote_min),
    .binary      (binary),
    .alarm       (alarm),
    .alarm_valid (alarm_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_ch(input int i, input logic signed [71:0] o,
                        input logic signed [49:0] b, input logic v);
    feat_out[i*OUT_W +: OUT_W]    = o;
    feat_base[i*BASE_W +: BASE_W] = b;
    feat_valid[i]                 = v;
  endtask

  task automatic write_scale(input logic [2:0] idx, input logic [7:0] data);
    scale_idx  = idx;
    scale_data = data;
    scale_wr   = 1'b1;
    tick();
    scale_wr   = 1'b0;
  endtask

  // Strobe at cycle T, then expect alarm_valid exactly in cycle T+8.
  task automatic run_window(input string tag, input logic [5:0] exp_bin, input logic exp_alarm);
    int n;
    win_stb = 1'b1;
    tick();
    win_stb = 1'b0;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    check({tag, ".ovr"}, 64'(overrun), 64'd0);
    n = 1;
    while (!alarm_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".lat"}, 64'(n), 64'd8);
    check({tag, ".bin"}, 64'(binary), 64'(exp_bin));
    check({tag, ".alarm"}, 64'(alarm), 64'(exp_alarm));
    tick();
    check({tag, ".pulse"}, 64'(alarm_valid), 64'd0);
  endtask

  initial begin
    logic signed [49:0] bmin;
    logic signed [49:0] bmax;
    logic signed [71:0] omin;
    logic signed [71:0] omax;
    int n;
    int saw;

    // Reset state
    tick();
    tick();
    check("rst.bin", 64'(binary), 64'd0);
    check("rst.alarm", 64'(alarm), 64'd0);
    check("rst.av", 64'(alarm_valid), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.ovr", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic threshold: ch0-2 exactly 2x base, ch3-5 one below
    for (int i = 0; i < N_CH; i++) write_scale(3'(i), 8'd2);
    persist_k = 4'd1;
    vote_min  = 3'd3;
    for (int i = 0; i < 3; i++) set_ch(i, 72'(2 * (100 + i)), 50'(100 + i), 1'b1);
    for (int i = 3; i < N_CH; i++) set_ch(i, 72'(2 * (100 + i) - 1), 50'(100 + i), 1'b1);
    run_window("basic", 6'b000111, 1'b1);

    // Repeated strobe at T+3 and scale write on ch4 during its evaluation at T+5
    win_stb = 1'b1;
    tick();
    win_stb = 1'b0;
    tick();
    tick();
    win_stb = 1'b1;
    tick();
    win_stb = 1'b0;
    check("ovr.pulse", 64'(overrun), 64'd1);
    check("ovr.busy", 64'(busy), 64'd1);
    tick();
    check("ovr.clear", 64'(overrun), 64'd0);
    scale_idx  = 3'd4;
    scale_data = 8'd1;
    scale_wr   = 1'b1;
    tick();
    scale_wr = 1'b0;
    n = 6;
    while (!alarm_valid && n < 20) begin
      tick();
      n++;
    end
    check("ovr.lat", 64'(n), 64'd8);
    check("ovr.bin", 64'(binary), 64'b000111);
    check("ovr.alarm", 64'(alarm), 64'd1);
    tick();

    // New scale on ch4 now applies; raise the vote bar above the 4 binaries
    vote_min = 3'd5;
    run_window("newscale", 6'b010111, 1'b0);
    write_scale(3'd4, 8'd2);
    write_scale(3'd6, 8'd0);

    // Signed boundaries: small negative and full-range baselines with scale 255
    bmin = {1'b1, 49'd0};
    bmax = {1'b0, {49{1'b1}}};
    omin = -(72'sd255 <<< 49);
    omax = (72'sd255 <<< 49) - 72'sd255;
    write_scale(3'd0, 8'd3);
    write_scale(3'd1, 8'd3);
    for (int i = 2; i < N_CH; i++) write_scale(3'(i), 8'd255);
    set_ch(0, -72'sd15, -50'sd5, 1'b1);
    set_ch(1, -72'sd16, -50'sd5, 1'b1);
    set_ch(2, omin, bmin, 1'b1);
    set_ch(3, omin - 72'sd1, bmin, 1'b1);
    set_ch(4, omax, bmax, 1'b1);
    set_ch(5, omax - 72'sd1, bmax, 1'b1);
    vote_min = 3'd3;
    run_window("signed", 6'b010101, 1'b1);

    // Persistence k=3: clear all counters, then ch0 hits 3x and misses once
    for (int i = 0; i < N_CH; i++) write_scale(3'(i), 8'd2);
    for (int i = 0; i < N_CH; i++) set_ch(i, 72'sd0, 50'sd100, 1'b1);
    vote_min = 3'd1;
    run_window("pclr", 6'b000000, 1'b0);
    persist_k = 4'd3;
    set_ch(0, 72'sd20, 50'sd10, 1'b1);
    run_window("p1", 6'b000000, 1'b0);
    run_window("p2", 6'b000000, 1'b0);
    run_window("p3", 6'b000001, 1'b1);
    set_ch(0, 72'sd19, 50'sd10, 1'b1);
    run_window("p4", 6'b000000, 1'b0);

    // Valid gating and vote_min=0
    persist_k = 4'd1;
    vote_min  = 3'd6;
    for (int i = 0; i < N_CH; i++) set_ch(i, 72'sd1000, 50'sd1, 1'b1);
    run_window("vall", 6'b111111, 1'b1);
    feat_valid[2] = 1'b0;
    vote_min = 3'd0;
    run_window("vgate", 6'b111011, 1'b1);
    for (int i = 0; i < N_CH; i++) set_ch(i, 72'sd0, 50'sd1, 1'b1);
    run_window("vmin0", 6'b000000, 1'b1);

    // persist_k=0 behaves as 1
    persist_k = 4'd0;
    vote_min  = 3'd2;
    set_ch(0, 72'sd5, 50'sd1, 1'b1);
    run_window("k0", 6'b000001, 1'b0);

    // Reset at T+3 aborts the window
    for (int i = 0; i < N_CH; i++) set_ch(i, 72'sd1000, 50'sd1, 1'b1);
    win_stb = 1'b1;
    tick();
    win_stb = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst.busy", 64'(busy), 64'd0);
    check("mrst.bin", 64'(binary), 64'd0);
    check("mrst.alarm", 64'(alarm), 64'd0);
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (alarm_valid || busy) saw++;
    end
    check("mrst.quiet", 64'(saw), 64'd0);
    rst_n = 1'b1;
    tick();

    // Fresh window after reset: scales back to 1, so out==base hits
    persist_k = 4'd1;
    vote_min  = 3'd4;
    for (int i = 0; i < 4; i++) set_ch(i, 72'sd7, 50'sd7, 1'b1);
    for (int i = 4; i < N_CH; i++) set_ch(i, 72'sd6, 50'sd7, 1'b1);
    run_window("post", 6'b001111, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
